heap_arb: RTL and testbench

HEAP_ARB -- requirements
Module: heap_arb

---
 rtl/heap_arb.sv | 176 +++++++++++++++++
 tb/tb_heap_arb.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_arb.sv
// heap_arb: round-robin client arbiter in front of a heap allocator port.
// Define HEAP_ARB_PAIR_EN to grant a matching alloc/free pair in one cycle.
`timescale 1ns/1ps
module heap_arb #(
    parameter  int DATA_SZ = 16,
    parameter  int CLI_SZ  = 2,
    localparam int N       = 1 << CLI_SZ
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_req,
    input  logic [2*N-1:0]       i_op,
    input  logic [DATA_SZ*N-1:0] i_addr,
    input  logic [DATA_SZ*N-1:0] i_data,
    output logic [N-1:0]         o_gnt,
    output logic                 o_rsp_v,
    output logic [CLI_SZ-1:0]    o_rsp_id,
    output logic [DATA_SZ-1:0]   o_rsp_data,
    output logic                 o_al,
    output logic [DATA_SZ-1:0]   o_adata,
    output logic                 o_fr,
    output logic [DATA_SZ-1:0]   o_faddr,
    output logic                 o_wr,
    output logic [DATA_SZ-1:0]   o_waddr,
    output logic [DATA_SZ-1:0]   o_wdata,
    output logic                 o_rd,
    output logic [DATA_SZ-1:0]   o_raddr,
    input  logic [DATA_SZ-1:0]   i_aaddr,
    input  logic [DATA_SZ-1:0]   i_rdata,
    input  logic                 i_full
);

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_AL = 2'b10;
    localparam logic [1:0] OP_FR = 2'b11;

    logic [CLI_SZ-1:0] r_ptr;
    logic [CLI_SZ-1:0] r_rsp_id;
    logic              r_al_last;
    logic              r_rsp_v;
    logic              r_rsp_al;

    logic [1:0]         w_op   [N];
    logic [DATA_SZ-1:0] w_addr [N];
    logic [DATA_SZ-1:0] w_data [N];
    logic [N-1:0]       w_elig;
    logic               w_pv;
    logic               w_sv;
    logic               w_go;
    logic               w_rsp;
    logic [CLI_SZ-1:0]  w_pi;
    logic [CLI_SZ-1:0]  w_si;
    logic [CLI_SZ-1:0]  w_pidx;
    logic [CLI_SZ-1:0]  w_rid;

    // An alloc right after an alloc waits: i_full lags the allocator by a cycle.
    for (genvar g = 0; g < N; g++) begin : g_cli
        assign w_op[g]   = i_op[2*g +: 2];
        assign w_addr[g] = i_addr[DATA_SZ*g +: DATA_SZ];
        assign w_data[g] = i_data[DATA_SZ*g +: DATA_SZ];
        assign w_elig[g] = i_req[g] &&
                           (w_op[g] != OP_AL || (!i_full && !r_al_last));
    end

    always_comb begin
        w_pv   = 1'b0;
        w_pi   = '0;
        w_pidx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_pidx = r_ptr + CLI_SZ'(off);
            if (w_elig[w_pidx]) begin
                w_pv = 1'b1;
                w_pi = w_pidx;
            end
        end
    end

`ifdef HEAP_ARB_PAIR_EN
    logic [1:0]        w_want;
    logic [CLI_SZ-1:0] w_sidx;

    always_comb begin
        w_sv   = 1'b0;
        w_si   = '0;
        w_sidx = '0;
        w_want = (w_op[w_pi] == OP_AL) ? OP_FR : OP_AL;
        for (int off = N - 1; off >= 1; off--) begin
            w_sidx = w_pi + CLI_SZ'(off);
            if (w_elig[w_sidx] && w_op[w_sidx] == w_want) begin
                w_sv = w_pv && w_op[w_pi][1];
                w_si = w_sidx;
            end
        end
    end
`else
    assign w_sv = 1'b0;
    assign w_si = '0;
`endif

    assign w_go = i_rst_n && w_pv;

    always_comb begin
        o_gnt   = '0;
        o_rd    = 1'b0;
        o_raddr = '0;
        o_wr    = 1'b0;
        o_waddr = '0;
        o_wdata = '0;
        o_al    = 1'b0;
        o_adata = '0;
        o_fr    = 1'b0;
        o_faddr = '0;
        if (w_go) begin
            o_gnt[w_pi] = 1'b1;
            unique case (w_op[w_pi])
                OP_RD: begin
                    o_rd    = 1'b1;
                    o_raddr = w_addr[w_pi];
                end
                OP_WR: begin
                    o_wr    = 1'b1;
                    o_waddr = w_addr[w_pi];
                    o_wdata = w_data[w_pi];
                end
                OP_AL: begin
                    o_al    = 1'b1;
                    o_adata = w_data[w_pi];
                end
                default: begin
                    o_fr    = 1'b1;
                    o_faddr = w_addr[w_pi];
                end
            endcase
            if (w_sv) begin
                o_gnt[w_si] = 1'b1;
                if (w_op[w_si] == OP_AL) begin
                    o_al    = 1'b1;
                    o_adata = w_data[w_si];
                end else begin
                    o_fr    = 1'b1;
                    o_faddr = w_addr[w_si];
                end
            end
        end
    end

    // A paired cycle always carries an alloc, so it always answers.
    assign w_rsp = w_go &&
                   (w_op[w_pi] == OP_RD || w_op[w_pi] == OP_AL || w_sv);
    assign w_rid = (w_sv && w_op[w_pi] == OP_FR) ? w_si : w_pi;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_al_last <= 1'b0;
            r_rsp_v   <= 1'b0;
            r_rsp_id  <= '0;
            r_rsp_al  <= 1'b0;
        end else begin
            r_al_last <= o_al;
            if (w_go) begin
                r_ptr <= w_pi + CLI_SZ'(1);
            end
            r_rsp_v  <= w_rsp;
            r_rsp_id <= w_rsp ? w_rid : '0;
            r_rsp_al <= w_rsp && (w_op[w_pi] == OP_AL || w_sv);
        end
    end

    // Allocator results arrive in the response cycle, so the payload is muxed live.
    assign o_rsp_v    = r_rsp_v;
    assign o_rsp_id   = r_rsp_id;
    assign o_rsp_data = !r_rsp_v ? '0 : (r_rsp_al ? i_aaddr : i_rdata);

endmodule

// File: tb/tb_heap_arb.sv
// Bench for heap_arb: vector table, directed corner sequences,
// and random traffic against a behavioural arbitration model.
`timescale 1ns/1ps
module tb_heap_arb;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]  req;
    logic [1:0]    op   [N];
    logic [DW-1:0] addr [N];
    logic [DW-1:0] data [N];
    logic          full;
    logic [DW-1:0] aaddr;
    logic [DW-1:0] rdata;

    logic [2*N-1:0]  p_op;
    logic [DW*N-1:0] p_addr;
    logic [DW*N-1:0] p_data;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign p_op[2*g +: 2]    = op[g];
        assign p_addr[DW*g +: DW] = addr[g];
        assign p_data[DW*g +: DW] = data[g];
    end

    logic [N-1:0]  o_gnt;
    logic          o_rsp_v;
    logic [1:0]    o_rsp_id;
    logic [DW-1:0] o_rsp_data;
    logic          o_al, o_fr, o_wr, o_rd;
    logic [DW-1:0] o_adata, o_faddr, o_waddr, o_wdata, o_raddr;

    heap_arb dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_op       (p_op),
        .i_addr     (p_addr),
        .i_data     (p_data),
        .o_gnt      (o_gnt),
        .o_rsp_v    (o_rsp_v),
        .o_rsp_id   (o_rsp_id),
        .o_rsp_data (o_rsp_data),
        .o_al       (o_al),
        .o_adata    (o_adata),
        .o_fr       (o_fr),
        .o_faddr    (o_faddr),
        .o_wr       (o_wr),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_rd       (o_rd),
        .o_raddr    (o_raddr),
        .i_aaddr    (aaddr),
        .i_rdata    (rdata),
        .i_full     (full)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Model state: pointer, alloc-last flag, pending response.
    int m_ptr, m_rid, n_ptr, n_rid;
    bit m_al_last, m_rv, m_ral, n_al_last, n_rv, n_ral;

    logic [N-1:0]  e_gnt;
    logic          e_rd, e_wr, e_al, e_fr;
    logic [DW-1:0] e_raddr, e_waddr, e_wdata, e_adata, e_faddr;

    logic [N-1:0]  s_gnt;
    logic [3:0]    s_str;
    logic          s_rv;
    logic [1:0]    s_rid;
    logic [DW-1:0] s_rdata;

    function automatic bit elig(int k);
        return req[k] && (op[k] != 2'd2 || (!full && !m_al_last));
    endfunction

    task automatic clear_exp();
        e_gnt = '0;
        {e_rd, e_wr, e_al, e_fr} = '0;
        {e_raddr, e_waddr, e_wdata, e_adata, e_faddr} = '0;
    endtask

    task automatic grant_to(int k);
        e_gnt[k] = 1'b1;
        case (op[k])
            2'd0: begin e_rd = 1'b1; e_raddr = addr[k]; end
            2'd1: begin e_wr = 1'b1; e_waddr = addr[k]; e_wdata = data[k]; end
            2'd2: begin e_al = 1'b1; e_adata = data[k]; end
            default: begin e_fr = 1'b1; e_faddr = addr[k]; end
        endcase
    endtask

    task automatic model_reset();
        m_ptr = 0; m_al_last = 0; m_rv = 0; m_ral = 0; m_rid = 0;
    endtask

    task automatic model_eval();
        int pri = -1;
        int sec = -1;
        clear_exp();
        for (int j = 0; j < N; j++)
            if (pri < 0 && elig((m_ptr + j) % N)) pri = (m_ptr + j) % N;
`ifdef HEAP_ARB_PAIR_EN
        if (pri >= 0 && op[pri] >= 2'd2)
            for (int j = 1; j < N; j++)
                if (sec < 0 && elig((pri + j) % N) &&
                    op[(pri + j) % N] == ((op[pri] == 2'd2) ? 2'd3 : 2'd2))
                    sec = (pri + j) % N;
`endif
        if (pri >= 0) grant_to(pri);
        if (sec >= 0) grant_to(sec);
        n_ptr     = (pri >= 0) ? (pri + 1) % N : m_ptr;
        n_al_last = e_al;
        n_rv  = pri >= 0 && (op[pri] == 2'd0 || op[pri] == 2'd2 || sec >= 0);
        n_ral = pri >= 0 && (op[pri] == 2'd2 || sec >= 0);
        n_rid = (sec >= 0 && op[pri] == 2'd3) ? sec : ((pri >= 0) ? pri : 0);
    endtask

    task automatic check_fields(input string tag);
        chk({tag, " raddr"}, o_raddr, e_raddr);
        chk({tag, " waddr"}, o_waddr, e_waddr);
        chk({tag, " wdata"}, o_wdata, e_wdata);
        chk({tag, " adata"}, o_adata, e_adata);
        chk({tag, " faddr"}, o_faddr, e_faddr);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, " gnt"}, o_gnt, e_gnt);
        chk({tag, " strobes"}, {o_al, o_fr, o_wr, o_rd}, {e_al, e_fr, e_wr, e_rd});
        check_fields(tag);
        chk({tag, " rsp_v"}, o_rsp_v, m_rv);
        if (m_rv) begin
            chk({tag, " rsp_id"}, o_rsp_id, m_rid);
            chk({tag, " rsp_data"}, o_rsp_data, m_ral ? aaddr : rdata);
        end
        s_gnt = o_gnt; s_str = {o_al, o_fr, o_wr, o_rd};
        s_rv = o_rsp_v; s_rid = o_rsp_id; s_rdata = o_rsp_data;
        @(posedge clk);
        m_ptr = n_ptr; m_al_last = n_al_last;
        m_rv = n_rv; m_ral = n_ral; m_rid = n_rid;
        #1;
    endtask

    task automatic consume();
        for (int k = 0; k < N; k++) if (e_gnt[k]) req[k] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        full = 1'b0;
        model_reset();
        clear_exp();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] op;
        logic       full;
        logic [3:0] gnt;
        logic [3:0] str;
    } vec_t;

    vec_t tbl[10];
    int   ord[5] = '{0, 1, 2, 3, 0};
    logic [3:0] one = 4'b0001;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        req = '0; full = 1'b0; aaddr = '0; rdata = '0;
        for (int k = 0; k < N; k++) begin
            op[k] = 2'd0; addr[k] = '0; data[k] = '0;
        end

        #1 rst_n = 1'b0;
        req = 4'hF;
        #1;
        chk("reset gnt", o_gnt, 4'h0);
        chk("reset strobes", {o_al, o_fr, o_wr, o_rd}, 4'h0);
        chk("reset rsp_v", o_rsp_v, 1'b0);
        chk("reset rsp_id", o_rsp_id, 2'd0);
        chk("reset rsp_data", o_rsp_data, 16'h0);
        req = '0;

        // {req, op, full, gnt, {al,fr,wr,rd}} from the reset state.
        tbl[0] = '{4'b0001, 8'b00_00_00_00, 1'b0, 4'b0001, 4'b0001};
        tbl[1] = '{4'b0110, 8'b00_00_01_00, 1'b0, 4'b0010, 4'b0010};
        tbl[2] = '{4'b1000, 8'b11_00_00_00, 1'b0, 4'b1000, 4'b0100};
        tbl[3] = '{4'b0001, 8'b00_00_00_10, 1'b1, 4'b0000, 4'b0000};
        tbl[4] = '{4'b0101, 8'b00_01_00_10, 1'b1, 4'b0100, 4'b0010};
        tbl[5] = '{4'b0100, 8'b00_10_00_00, 1'b0, 4'b0100, 4'b1000};
        tbl[6] = '{4'b0000, 8'b00_00_00_00, 1'b0, 4'b0000, 4'b0000};
`ifdef HEAP_ARB_PAIR_EN
        tbl[7] = '{4'b1001, 8'b11_00_00_10, 1'b0, 4'b1001, 4'b1100};
        tbl[8] = '{4'b1110, 8'b00_10_11_00, 1'b0, 4'b0110, 4'b1100};
`else
        tbl[7] = '{4'b1001, 8'b11_00_00_10, 1'b0, 4'b0001, 4'b1000};
        tbl[8] = '{4'b1110, 8'b00_10_11_00, 1'b0, 4'b0010, 4'b0100};
`endif
        tbl[9] = '{4'b1010, 8'b11_00_11_00, 1'b0, 4'b0010, 4'b0100};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            req = '0;
            #1 rst_n = 1'b1;
            for (int k = 0; k < N; k++) begin
                op[k]   = tbl[i].op[2*k +: 2];
                addr[k] = 16'h1000 + 16'(k);
                data[k] = 16'h2000 + 16'(k);
            end
            full = tbl[i].full;
            req  = tbl[i].req;
            #1;
            clear_exp();
            for (int k = 0; k < N; k++) if (tbl[i].gnt[k]) grant_to(k);
            chk($sformatf("vec%0d gnt", i), o_gnt, tbl[i].gnt);
            chk($sformatf("vec%0d strobes", i), {o_al, o_fr, o_wr, o_rd}, tbl[i].str);
            check_fields($sformatf("vec%0d", i));
            req = '0;
            full = 1'b0;
        end

        // Continuous reads from all clients rotate 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b1; op[k] = 2'd0; addr[k] = 16'h1010 + 16'(k);
        end
        for (int i = 0; i < 5; i++) begin
            rdata = 16'hA000 + 16'(i);
            step("rr");
            chk("rr order", s_gnt, one << ord[i]);
            if (i > 0) chk("rr rsp_id", s_rid, ord[i-1]);
        end

        // Back-to-back allocs from one client alternate.
        do_reset();
        req[1] = 1'b1; op[1] = 2'd2; data[1] = 16'h0042;
        aaddr = 16'h0; step("al0");
        chk("al0 gnt", s_gnt, 4'b0010);
        aaddr = 16'h5000; step("al1");
        chk("al1 gnt", s_gnt, 4'b0000);
        chk("al1 rsp_data", s_rdata, 16'h5000);
        aaddr = 16'hDEAD; step("al2");
        chk("al2 gnt", s_gnt, 4'b0010);
        aaddr = 16'h5001; step("al3");
        chk("al3 gnt", s_gnt, 4'b0000);
        chk("al3 rsp_data", s_rdata, 16'h5001);
        req = '0;

        // Heap full: alloc waits while a write passes.
        do_reset();
        full = 1'b1;
        req[0] = 1'b1; op[0] = 2'd2; data[0] = 16'h0011;
        req[2] = 1'b1; op[2] = 2'd1; addr[2] = 16'h3000; data[2] = 16'h3333;
        step("full0"); chk("full0 gnt", s_gnt, 4'b0100); consume();
        step("full1"); chk("full1 gnt", s_gnt, 4'b0000);
        full = 1'b0;
        step("full2"); chk("full2 gnt", s_gnt, 4'b0001); consume();

        // Alloc on client 0 alongside a free on client 3.
        do_reset();
        req[0] = 1'b1; op[0] = 2'd2; data[0] = 16'h0077;
        req[3] = 1'b1; op[3] = 2'd3; addr[3] = 16'h5007;
        step("pair0");
`ifdef HEAP_ARB_PAIR_EN
        chk("pair0 gnt", s_gnt, 4'b1001);
        chk("pair0 strobes", s_str, 4'b1100);
`else
        chk("pair0 gnt", s_gnt, 4'b0001);
        chk("pair0 strobes", s_str, 4'b1000);
`endif
        consume();
        aaddr = 16'h5007;
        step("pair1");
        chk("pair1 rsp_v", s_rv, 1'b1);
        chk("pair1 rsp_id", s_rid, 2'd0);
        chk("pair1 rsp_data", s_rdata, 16'h5007);
`ifndef HEAP_ARB_PAIR_EN
        chk("pair1 gnt", s_gnt, 4'b1000);
`endif
        consume();

        // Reset between a read grant and its response.
        do_reset();
        req[2] = 1'b1; op[2] = 2'd0; addr[2] = 16'h2222; rdata = 16'h1234;
        step("mid0"); chk("mid0 gnt", s_gnt, 4'b0100); consume();
        req[3] = 1'b1; op[3] = 2'd0; addr[3] = 16'h3333;
        @(negedge clk);
        chk("mid1 gnt", o_gnt, 4'b1000);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid rst gnt", o_gnt, 4'b0000);
        chk("mid rst rsp_v", o_rsp_v, 1'b0);
        @(posedge clk); #1;
        chk("mid rst hold rsp_v", o_rsp_v, 1'b0);
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid release rsp_v", o_rsp_v, 1'b0);
        req[2] = 1'b1; req[3] = 1'b1; op[2] = 2'd0;
        step("mid2"); chk("mid2 first gnt", s_gnt, 4'b0100); consume();

        // Random traffic with held requests.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            consume();
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 1) == 1) begin
                    req[k]  = 1'b1;
                    op[k]   = 2'($urandom_range(0, 3));
                    addr[k] = 16'($urandom);
                    data[k] = 16'($urandom);
                end
            end
            full  = ($urandom_range(0, 3) == 0);
            aaddr = 16'($urandom);
            rdata = 16'($urandom);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
